// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, funct codes and issue-bundle type shared by decode_issue
package decode_pkg;

  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_FMV = 3'b001;
  localparam logic [2:0] OP_F   = 3'b010;
  localparam logic [2:0] OP_I   = 3'b100;
  localparam logic [2:0] OP_L   = 3'b101;
  localparam logic [2:0] OP_B   = 3'b110;
  localparam logic [2:0] OP_J   = 3'b111;

  // Jump flavours under OP_J; memory kind is funct[2:1] under OP_L.
  localparam logic [2:0] FN_J    = 3'b000;
  localparam logic [2:0] FN_JAL  = 3'b001;
  localparam logic [2:0] FN_JALR = 3'b010;
  localparam logic [1:0] FN_LD   = 2'b00;
  localparam logic [1:0] FN_ST   = 2'b01;

  localparam logic [5:0] REG_ZERO  = 6'b000000;
  localparam logic [5:0] REG_FZERO = 6'b100000;

  typedef struct packed {
    logic [6:0] aluctl;
    logic [6:0] rd;
    logic       mre;
    logic       mwe;
    logic [6:0] branch;
    logic       jump;
  } issue_bundle_t;

  function automatic logic no_fwd(input logic [5:0] a);
    return (a == REG_ZERO) || (a == REG_FZERO);
  endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// rtl/dec_scoreboard.sv - per-register result-latency counters, reports busy source registers
module dec_scoreboard #(
  parameter int LOAD_LAT = 2,
  parameter int FPU_LAT  = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic       set_fp_i,
  input  logic [5:0] set_rd_i,
  input  logic [5:0] rs1_i,
  input  logic [5:0] rs2_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o
);

  localparam int MAXLAT = (LOAD_LAT > FPU_LAT) ? LOAD_LAT : FPU_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  logic [CW-1:0] cnt_q [64];
  logic [CW-1:0] cnt_d [64];

  // A fresh issue write wins over the countdown of the same register.
  always_comb begin
    for (int r = 0; r < 64; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CW'(1);
      if (set_i && (set_rd_i == 6'(r))) cnt_d[r] = set_fp_i ? CW'(FPU_LAT) : CW'(LOAD_LAT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= '{default: '0};
    else        cnt_q <= cnt_d;
  end

  assign rs1_busy_o = (cnt_q[rs1_i] != '0);
  assign rs2_busy_o = (cnt_q[rs2_i] != '0);

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode/issue stage: forwarding, latency scoreboard, valid/ready issue register
// Optional perf_issue_cnt/perf_hazard_cnt outputs under DECODE_ISSUE_PERF_EN.
module decode_issue
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_W     = 27,
  parameter int ADDR_W   = 30,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 2,
  parameter int FPU_LAT  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_valid_i,
  input  logic [31:0]          if_inst_i,
  input  logic [PC_W-1:0]      if_pc_i,
  output logic                 if_ready_o,
  output logic [5:0]           rs1_addr_o,
  output logic [5:0]           rs2_addr_o,
  input  logic [XLEN-1:0]      rs1_rdata_i,
  input  logic [XLEN-1:0]      rs2_rdata_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD*6-1:0]    fwd_rd_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic                 flush_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [XLEN-1:0]      dec_op1_o,
  output logic [XLEN-1:0]      dec_op2_o,
  output logic [6:0]           dec_aluctl_o,
  output logic [6:0]           dec_rd_o,
  output logic                 dec_mre_o,
  output logic                 dec_mwe_o,
  output logic [6:0]           dec_branch_o,
  output logic                 dec_jump_o,
  output logic [PC_W-1:0]      dec_npc_o,
  output logic [ADDR_W-1:0]    dec_daddr_o
`ifdef DECODE_ISSUE_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt_o,
  output logic [31:0]          perf_hazard_cnt_o
`endif
);

  logic [2:0]      op, funct;
  logic            isfloat, is_load, rd_valid, rs2_used;
  logic [XLEN-1:0] imm_il, imm_sb, rs1_val, rs2_val;
  logic            rs1_busy, rs2_busy, hazard, load_en, issue, sb_set;

  issue_bundle_t   bundle_d, bundle_q;
  logic [XLEN-1:0] op1_d, op1_q, op2_d, op2_q;
  logic [PC_W-1:0] npc_d, npc_q;
  logic [ADDR_W-1:0] daddr_d, daddr_q;
  logic            dec_valid_q;

  assign op       = if_inst_i[2:0];
  assign funct    = if_inst_i[5:3];
  assign isfloat  = (op == OP_F);
  assign is_load  = (op == OP_L) && (funct[2:1] == FN_LD);
  assign rs2_used = op inside {OP_R, OP_FMV, OP_F, OP_B};
  assign imm_il   = {{(XLEN-16){if_inst_i[21]}}, if_inst_i[21:6]};
  assign imm_sb   = {{(XLEN-16){if_inst_i[26]}}, if_inst_i[26:11]};

  assign rs1_addr_o = {isfloat, if_inst_i[31:27]};
  assign rs2_addr_o = {isfloat, if_inst_i[10:6]};

  // Walk sources oldest-first so the youngest matching one is written last.
  always_comb begin
    rs1_val = rs1_rdata_i;
    rs2_val = rs2_rdata_i;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_rd_i[i*6 +: 6] == rs1_addr_o) && !no_fwd(rs1_addr_o))
        rs1_val = fwd_data_i[i*XLEN +: XLEN];
      if (fwd_valid_i[i] && (fwd_rd_i[i*6 +: 6] == rs2_addr_o) && !no_fwd(rs2_addr_o))
        rs2_val = fwd_data_i[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    case (op)
      OP_R, OP_FMV, OP_F, OP_I: rd_valid = 1'b1;
      OP_L:                     rd_valid = is_load;
      OP_J:                     rd_valid = (funct != FN_J);
      default:                  rd_valid = 1'b0;
    endcase
  end

  always_comb begin
    bundle_d.aluctl = {if_inst_i[11], op, funct};
    bundle_d.rd     = {rd_valid, isfloat, if_inst_i[26:22]};
    bundle_d.mre    = is_load;
    bundle_d.mwe    = (op == OP_L) && (funct[2:1] == FN_ST);
    bundle_d.jump   = (op == OP_J);
    bundle_d.branch = '0;
    if (op == OP_B) begin
      bundle_d.branch[6] = 1'b1;
      for (int b = 0; b < 6; b++) bundle_d.branch[b] = (funct == 3'(b));
    end
  end

  always_comb begin
    op1_d = (op == OP_J) ? XLEN'(if_pc_i) : rs1_val;
    case (op)
      OP_I, OP_L: op2_d = imm_il;
      OP_J:       op2_d = XLEN'(4);
      default:    op2_d = rs2_val;
    endcase
    daddr_d = ADDR_W'(rs1_val + imm_il);
    if (op == OP_J && funct == FN_J)         npc_d = if_pc_i + PC_W'({if_inst_i[30:6], 2'b00});
    else if (op == OP_J && funct == FN_JAL)  npc_d = if_pc_i + PC_W'({imm_il, 2'b00});
    else if (op == OP_J && funct == FN_JALR) npc_d = rs1_val[PC_W-1:0] + PC_W'({imm_il, 2'b00});
    else                                     npc_d = if_pc_i + PC_W'({imm_sb, 2'b00});
  end

  assign hazard     = rs1_busy | (rs2_used & rs2_busy);
  assign load_en    = ~dec_valid_q | dec_ready_i;
  assign if_ready_o = rst_i & load_en & ~hazard;
  assign issue      = if_valid_i & if_ready_o & ~flush_i;
  assign sb_set     = issue & ((is_load & (if_inst_i[26:22] != 5'd0)) | isfloat);

  dec_scoreboard #(.LOAD_LAT(LOAD_LAT), .FPU_LAT(FPU_LAT)) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (sb_set),
    .set_fp_i  (isfloat),
    .set_rd_i  ({isfloat, if_inst_i[26:22]}),
    .rs1_i     (rs1_addr_o),
    .rs2_i     (rs2_addr_o),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dec_valid_q <= 1'b0;
      bundle_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      npc_q       <= '0;
      daddr_q     <= '0;
    end else begin
      if (flush_i)      dec_valid_q <= 1'b0;
      else if (load_en) dec_valid_q <= issue;
      if (issue) begin
        bundle_q <= bundle_d;
        op1_q    <= op1_d;
        op2_q    <= op2_d;
        npc_q    <= npc_d;
        daddr_q  <= daddr_d;
      end
    end
  end

  assign dec_valid_o  = dec_valid_q;
  assign dec_op1_o    = op1_q;
  assign dec_op2_o    = op2_q;
  assign dec_aluctl_o = bundle_q.aluctl;
  assign dec_rd_o     = bundle_q.rd;
  assign dec_mre_o    = bundle_q.mre;
  assign dec_mwe_o    = bundle_q.mwe;
  assign dec_branch_o = bundle_q.branch;
  assign dec_jump_o   = bundle_q.jump;
  assign dec_npc_o    = npc_q;
  assign dec_daddr_o  = daddr_q;

`ifdef DECODE_ISSUE_PERF_EN
  logic [31:0] perf_issue_q, perf_hazard_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_issue_q  <= '0;
      perf_hazard_q <= '0;
    end else begin
      if (issue)                            perf_issue_q  <= perf_issue_q + 32'd1;
      if (if_valid_i && hazard && load_en)  perf_hazard_q <= perf_hazard_q + 32'd1;
    end
  end

  assign perf_issue_cnt_o  = perf_issue_q;
  assign perf_hazard_cnt_o = perf_hazard_q;
`endif

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed self-checking bench for decode_issue
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [26:0] if_pc = '0;
  logic        if_ready;
  logic [5:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic [1:0]  fwd_valid = '0;
  logic [11:0] fwd_rd = '0;
  logic [63:0] fwd_data = '0;
  logic        flush = 1'b0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_op1, dec_op2;
  logic [6:0]  dec_aluctl, dec_rd, dec_branch;
  logic        dec_mre, dec_mwe, dec_jump;
  logic [26:0] dec_npc;
  logic [29:0] dec_daddr;
`ifdef DECODE_ISSUE_PERF_EN
  logic [31:0] perf_issue_cnt, perf_hazard_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Register file contents: register n reads as 0x1000 + n.
  assign rs1_rdata = 32'h1000 + 32'(rs1_addr);
  assign rs2_rdata = 32'h1000 + 32'(rs2_addr);

  decode_issue dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_valid_i  (if_valid),
    .if_inst_i   (if_inst),
    .if_pc_i     (if_pc),
    .if_ready_o  (if_ready),
    .rs1_addr_o  (rs1_addr),
    .rs2_addr_o  (rs2_addr),
    .rs1_rdata_i (rs1_rdata),
    .rs2_rdata_i (rs2_rdata),
    .fwd_valid_i (fwd_valid),
    .fwd_rd_i    (fwd_rd),
    .fwd_data_i  (fwd_data),
    .flush_i     (flush),
    .dec_valid_o (dec_valid),
    .dec_ready_i (dec_ready),
    .dec_op1_o   (dec_op1),
    .dec_op2_o   (dec_op2),
    .dec_aluctl_o(dec_aluctl),
    .dec_rd_o    (dec_rd),
    .dec_mre_o   (dec_mre),
    .dec_mwe_o   (dec_mwe),
    .dec_branch_o(dec_branch),
    .dec_jump_o  (dec_jump),
    .dec_npc_o   (dec_npc),
    .dec_daddr_o (dec_daddr)
`ifdef DECODE_ISSUE_PERF_EN
    ,
    .perf_issue_cnt_o (perf_issue_cnt),
    .perf_hazard_cnt_o(perf_hazard_cnt)
`endif
  );

  function automatic logic [31:0] enc_r(input logic [2:0] op, input logic [2:0] fn,
                                        input logic [4:0] rs1, input logic [4:0] rd, input logic [4:0] rs2);
    return {rs1, rd, 11'd0, rs2, fn, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [2:0] op, input logic [2:0] fn,
                                        input logic [4:0] rs1, input logic [4:0] rd, input logic [15:0] imm);
    return {rs1, rd, imm, fn, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] fn, input logic [4:0] rs1,
                                        input logic [15:0] imm, input logic [4:0] rs2);
    return {rs1, imm, rs2, fn, 3'b110};
  endfunction

  task automatic test_reset();
    rst = 1'b0; if_valid = 1'b1; if_inst = enc_r(3'b000, 3'b000, 5'd1, 5'd2, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
    vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", if_ready); end
    vectors++;
    if ({dec_op1, dec_op2, dec_aluctl, dec_rd, dec_mre, dec_mwe, dec_branch, dec_jump, dec_npc, dec_daddr} !== '0) begin
      miscompares++; $display("FAIL reset_data: op1=%h op2=%h npc=%h daddr=%h want all 0", dec_op1, dec_op2, dec_npc, dec_daddr);
    end
    rst = 1'b1; if_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid: got %b want 0", dec_valid); end
  endtask

  task automatic test_load_use();
    int stalls;
    dec_ready = 1'b1; if_pc = 27'h40; if_valid = 1'b1;
    if_inst = enc_i(3'b101, 3'b000, 5'd1, 5'd5, 16'd8);
    #1;
    vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL lu_lw_ready: got %b want 1", if_ready); end
    @(posedge clk); #1;
    vectors++; if (dec_valid !== 1'b1) begin miscompares++; $display("FAIL lu_lw_valid: got %b want 1", dec_valid); end
    vectors++; if (dec_mre !== 1'b1) begin miscompares++; $display("FAIL lu_lw_mre: got %b want 1", dec_mre); end
    vectors++; if (dec_rd !== 7'h45) begin miscompares++; $display("FAIL lu_lw_rd: got %h want 45", dec_rd); end
    vectors++; if (dec_daddr !== 30'h1009) begin miscompares++; $display("FAIL lu_lw_daddr: got %h want 1009", dec_daddr); end
    if_inst = enc_r(3'b000, 3'b000, 5'd5, 5'd6, 5'd7);
    #1;
    stalls = 0;
    while (!if_ready && stalls < 10) begin
      @(posedge clk); #1;
      stalls++;
    end
    vectors++; if (stalls !== 2) begin miscompares++; $display("FAIL lu_stalls: got %0d want 2", stalls); end
    vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble: got %b want 0", dec_valid); end
    @(posedge clk); #1;
    vectors++; if (dec_valid !== 1'b1) begin miscompares++; $display("FAIL lu_add_valid: got %b want 1", dec_valid); end
    vectors++; if (dec_op1 !== 32'h1005) begin miscompares++; $display("FAIL lu_add_op1: got %h want 1005", dec_op1); end
    vectors++; if (dec_op2 !== 32'h1007) begin miscompares++; $display("FAIL lu_add_op2: got %h want 1007", dec_op2); end
    vectors++; if (dec_rd !== 7'h46) begin miscompares++; $display("FAIL lu_add_rd: got %h want 46", dec_rd); end
    if_valid = 1'b0;
  endtask

  task automatic test_forwarding();
    if_valid = 1'b1;
    fwd_valid = 2'b11; fwd_rd = {6'd3, 6'd3}; fwd_data = {32'h5555, 32'hAAAA};
    if_inst = enc_r(3'b000, 3'b000, 5'd3, 5'd8, 5'd4);
    @(posedge clk); #1;
    vectors++; if (dec_op1 !== 32'hAAAA) begin miscompares++; $display("FAIL fwd_youngest: got %h want aaaa", dec_op1); end
    vectors++; if (dec_op2 !== 32'h1004) begin miscompares++; $display("FAIL fwd_rs2_rf: got %h want 1004", dec_op2); end
    fwd_valid = 2'b10;
    @(posedge clk); #1;
    vectors++; if (dec_op1 !== 32'h5555) begin miscompares++; $display("FAIL fwd_older: got %h want 5555", dec_op1); end
    fwd_valid = 2'b11; fwd_rd = {6'd0, 6'd0};
    if_inst = enc_r(3'b000, 3'b000, 5'd0, 5'd8, 5'd4);
    @(posedge clk); #1;
    vectors++; if (dec_op1 !== 32'h1000) begin miscompares++; $display("FAIL fwd_r0: got %h want 1000", dec_op1); end
    fwd_rd = {6'h20, 6'h20};
    if_inst = enc_r(3'b010, 3'b000, 5'd0, 5'd12, 5'd1);
    @(posedge clk); #1;
    vectors++; if (dec_op1 !== 32'h1020) begin miscompares++; $display("FAIL fwd_f0: got %h want 1020", dec_op1); end
    vectors++; if (dec_op2 !== 32'h1021) begin miscompares++; $display("FAIL fwd_f1_rf: got %h want 1021", dec_op2); end
    if_valid = 1'b0; fwd_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    dec_ready = 1'b1; if_valid = 1'b1;
    if_inst = enc_r(3'b000, 3'b000, 5'd1, 5'd10, 5'd2);
    @(posedge clk); #1;
    dec_ready = 1'b0;
    if_inst = enc_i(3'b100, 3'b000, 5'd1, 5'd11, 16'd5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0", k, if_ready); end
      vectors++;
      if (dec_valid !== 1'b1 || dec_rd !== 7'h4A || dec_op1 !== 32'h1001 || dec_op2 !== 32'h1002) begin
        miscompares++; $display("FAIL bp_hold[%0d]: valid=%b rd=%h op1=%h op2=%h want 1/4a/1001/1002", k, dec_valid, dec_rd, dec_op1, dec_op2);
      end
    end
    dec_ready = 1'b1;
    #1;
    vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", if_ready); end
    @(posedge clk); #1;
    vectors++; if (dec_rd !== 7'h4B) begin miscompares++; $display("FAIL bp_next_rd: got %h want 4b", dec_rd); end
    vectors++; if (dec_op2 !== 32'd5) begin miscompares++; $display("FAIL bp_next_imm: got %h want 5", dec_op2); end
    vectors++; if (dec_aluctl !== 7'h20) begin miscompares++; $display("FAIL bp_next_aluctl: got %h want 20", dec_aluctl); end
  endtask

  task automatic test_flush();
    if_valid = 1'b1; flush = 1'b1;
    if_inst = enc_i(3'b100, 3'b000, 5'd1, 5'd13, 16'd7);
    @(posedge clk); #1;
    vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", dec_valid); end
    vectors++; if (dec_rd !== 7'h4B) begin miscompares++; $display("FAIL flush_no_issue: got %h want 4b", dec_rd); end
    flush = 1'b0;
    @(posedge clk); #1;
    vectors++; if (dec_valid !== 1'b1 || dec_rd !== 7'h4D) begin
      miscompares++; $display("FAIL flush_resume: valid=%b rd=%h want 1/4d", dec_valid, dec_rd);
    end
    if_valid = 1'b0;
  endtask

  task automatic test_targets();
    if_valid = 1'b1;
    if_pc = 27'h0; if_inst = enc_i(3'b111, 3'b001, 5'd0, 5'd1, 16'hFFFF);
    @(posedge clk); #1;
    vectors++; if (dec_npc !== 27'h7FFFFFC) begin miscompares++; $display("FAIL jal_wrap_npc: got %h want 7fffffc", dec_npc); end
    vectors++; if (dec_jump !== 1'b1 || dec_op1 !== 32'h0 || dec_op2 !== 32'h4 || dec_rd !== 7'h41) begin
      miscompares++; $display("FAIL jal_link: jump=%b op1=%h op2=%h rd=%h want 1/0/4/41", dec_jump, dec_op1, dec_op2, dec_rd);
    end
    if_pc = 27'h50; fwd_valid = 2'b01; fwd_rd = {6'd0, 6'd2}; fwd_data = {32'h0, 32'h100};
    if_inst = enc_i(3'b111, 3'b010, 5'd2, 5'd1, 16'd2);
    @(posedge clk); #1;
    vectors++; if (dec_npc !== 27'h108) begin miscompares++; $display("FAIL jalr_npc: got %h want 108", dec_npc); end
    vectors++; if (dec_op1 !== 32'h50) begin miscompares++; $display("FAIL jalr_link_pc: got %h want 50", dec_op1); end
    fwd_valid = 2'b00;
    if_pc = 27'h7FFFFF0; if_inst = {1'b0, 25'd4, 3'b000, 3'b111};
    @(posedge clk); #1;
    vectors++; if (dec_npc !== 27'h0) begin miscompares++; $display("FAIL j_wrap_npc: got %h want 0", dec_npc); end
    vectors++; if (dec_rd !== 7'h00) begin miscompares++; $display("FAIL j_no_rd: got %h want 00", dec_rd); end
    if_pc = 27'h100; if_inst = enc_b(3'b010, 5'd1, 16'hFFFE, 5'd2);
    @(posedge clk); #1;
    vectors++; if (dec_npc !== 27'hF8) begin miscompares++; $display("FAIL br_npc: got %h want f8", dec_npc); end
    vectors++; if (dec_branch !== 7'h44 || dec_jump !== 1'b0) begin
      miscompares++; $display("FAIL br_cond: branch=%h jump=%b want 44/0", dec_branch, dec_jump);
    end
    if_valid = 1'b0;
  endtask

  task automatic test_fpu_latency();
    int stalls;
    if_valid = 1'b1;
    if_inst = enc_r(3'b010, 3'b000, 5'd1, 5'd9, 5'd1);
    @(posedge clk); #1;
    vectors++; if (dec_rd !== 7'h69) begin miscompares++; $display("FAIL fp_rd: got %h want 69", dec_rd); end
    if_inst = enc_r(3'b010, 3'b000, 5'd9, 5'd10, 5'd1);
    #1;
    stalls = 0;
    while (!if_ready && stalls < 10) begin
      @(posedge clk); #1;
      stalls++;
    end
    vectors++; if (stalls !== 3) begin miscompares++; $display("FAIL fp_stalls: got %0d want 3", stalls); end
    @(posedge clk); #1;
    vectors++; if (dec_valid !== 1'b1 || dec_op1 !== 32'h1029) begin
      miscompares++; $display("FAIL fp_dep_issue: valid=%b op1=%h want 1/1029", dec_valid, dec_op1);
    end
    if_inst = enc_i(3'b101, 3'b000, 5'd1, 5'd0, 16'd0);
    @(posedge clk); #1;
    if_inst = enc_r(3'b000, 3'b000, 5'd0, 5'd14, 5'd0);
    #1;
    vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL ld_r0_noblock: got %b want 1", if_ready); end
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_backpressure();
    test_flush();
    test_targets();
    test_fpu_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1, "timeout");
  end

endmodule
